multi_timer: RTL and testbench

- Parametrised successor to the single-channel bus timer: NCH independent down-counters behind one word-addressed register bus. Each channel has its own prescaler, mode, sticky interrupt flag and interrupt mask.
- Sits on the CPU peripheral bus next to memory and other devices.
- Drives a single level-sensitive irq line to the CPU interrupt logic.

---
 rtl/multi_timer_if.sv | 22 ++
 rtl/multi_timer.sv | 126 ++++++++++++
 tb/tb_multi_timer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// multi_timer register bus: word address, write strobe, write data
// and registered read data.
interface multi_timer_if;
  logic [5:2]  addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output addr,
    output we,
    output data_in,
    input  data_out
  );

  modport slave (
    input  addr,
    input  we,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/multi_timer.sv
// NCH independent prescaled down-counters behind one word-addressed
// register bus, with sticky per-channel flags and a shared irq line.
module multi_timer #(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int PSC_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  multi_timer_if.slave   bus,
  output logic           irq
);

  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_im;
  logic [NCH-1:0]   r_pend;
  logic [1:0]       r_mode   [NCH];
  logic [PSC_W-1:0] r_psc    [NCH];
  logic [PSC_W-1:0] r_pcnt   [NCH];
  logic [W-1:0]     r_preset [NCH];
  logic [W-1:0]     r_count  [NCH];

  logic [1:0]     w_ch;
  logic [1:0]     w_reg;
  logic [3:0]     w_sel;
  logic [NCH-1:0] w_wctrl;
  logic [NCH-1:0] w_wpre;
  logic [NCH-1:0] w_wstat;
  logic [NCH-1:0] w_tick;
  logic [NCH-1:0] w_go;
  logic [31:0]    w_rd;

  assign w_ch  = bus.addr[5:4];
  assign w_reg = bus.addr[3:2];
  // one-hot channel select; bits at or above NCH are never consulted
  assign w_sel = 4'b0001 << w_ch;

  always_comb begin
    w_wctrl = '0;
    w_wpre  = '0;
    w_wstat = '0;
    w_tick  = '0;
    w_go    = '0;
    for (int c = 0; c < NCH; c++) begin
      w_wctrl[c] = bus.we && w_sel[c] && (w_reg == 2'd0);
      w_wpre[c]  = bus.we && w_sel[c] && (w_reg == 2'd1);
      w_wstat[c] = bus.we && w_sel[c] && (w_reg == 2'd3);
      w_tick[c]  = r_en[c] && (r_pcnt[c] == r_psc[c]);
      w_go[c]    = w_tick[c] && !w_wctrl[c] && !w_wpre[c];
    end
  end

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_sel[c]) begin
        unique case (w_reg)
          2'd0: begin
            w_rd[0]          = r_en[c];
            w_rd[2:1]        = r_mode[c];
            w_rd[3]          = r_im[c];
            w_rd[8 +: PSC_W] = r_psc[c];
          end
          2'd1:    w_rd[W-1:0] = r_preset[c];
          2'd2:    w_rd[W-1:0] = r_count[c];
          default: w_rd[0]     = r_pend[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= '0;
      r_im         <= '0;
      r_pend       <= '0;
      bus.data_out <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_mode[c]   <= '0;
        r_psc[c]    <= '0;
        r_pcnt[c]   <= '0;
        r_preset[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      bus.data_out <= w_rd;
      for (int c = 0; c < NCH; c++) begin
        if (w_wctrl[c] || w_wpre[c] || !r_en[c] || w_tick[c])
          r_pcnt[c] <= '0;
        else
          r_pcnt[c] <= r_pcnt[c] + PSC_W'(1);

        if (w_wctrl[c]) begin
          r_en[c]   <= bus.data_in[0];
          r_mode[c] <= bus.data_in[2:1];
          r_im[c]   <= bus.data_in[3];
          r_psc[c]  <= bus.data_in[8 +: PSC_W];
        end

        if (w_wpre[c]) begin
          r_preset[c] <= bus.data_in[W-1:0];
          r_count[c]  <= bus.data_in[W-1:0];
        end else if (w_go[c]) begin
          if (r_count[c] != '0)
            r_count[c] <= r_count[c] - W'(1);
          else begin
            unique case (r_mode[c])
              2'b01:   r_count[c] <= r_preset[c];
              2'b10:   r_count[c] <= '1;
              default: r_en[c]    <= 1'b0;
            endcase
          end
        end

        // a terminal-count set beats a simultaneous clear
        if (w_go[c] && (r_count[c] == W'(1)))
          r_pend[c] <= 1'b1;
        else if (w_wstat[c] && bus.data_in[0])
          r_pend[c] <= 1'b0;
      end
    end
  end

  assign irq = |(r_pend & r_im);

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed vector table, hand sequences for
// collisions/wrap/reset, then random traffic against a reference model.
module tb_multi_timer;
  localparam int NCH   = 3;
  localparam int W     = 16;
  localparam int PSC_W = 8;
  localparam bit [31:0] MASK = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  multi_timer_if bus ();

  multi_timer #(.NCH(NCH), .W(W), .PSC_W(PSC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(logic we, logic [3:0] a, logic [31:0] d);
    bus.we      = we;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_do;
    logic        exp_irq;
  } vec_t;

  vec_t tq[$];

  // reference model: per-channel state, cycles remaining to next tick
  bit          m_en   [4];
  bit          m_im   [4];
  bit          m_pend [4];
  bit [1:0]    m_mode [4];
  int unsigned m_psc  [4];
  int unsigned m_pre  [4];
  int unsigned m_cnt  [4];
  int unsigned m_wait [4];
  bit [31:0]   m_dout;
  bit          m_irq;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_im[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
      m_psc[i] = 0; m_pre[i] = 0; m_cnt[i] = 0; m_wait[i] = 0;
    end
    m_dout = 0;
    m_irq  = 0;
  endfunction

  function automatic void m_step(bit we, bit [3:0] a, bit [31:0] d);
    int c = int'(a[3:2]);
    int r = int'(a[1:0]);
    bit tick [4];
    m_dout = 0;
    if (c < NCH) begin
      case (r)
        0: m_dout = 32'(m_en[c]) | (32'(m_mode[c]) << 1) |
                    (32'(m_im[c]) << 3) | (m_psc[c] << 8);
        1: m_dout = m_pre[c];
        2: m_dout = m_cnt[c];
        default: m_dout = 32'(m_pend[c]);
      endcase
    end
    for (int i = 0; i < NCH; i++) tick[i] = m_en[i] && (m_wait[i] == 0);
    for (int i = 0; i < NCH; i++) begin
      bit hit = we && (c == i);
      bit set = 0;
      if (hit && r == 0) begin
        m_en[i]   = d[0];
        m_mode[i] = d[2:1];
        m_im[i]   = d[3];
        m_psc[i]  = (d >> 8) & 32'hFF;
        m_wait[i] = m_psc[i];
      end else if (hit && r == 1) begin
        m_pre[i]  = d & MASK;
        m_cnt[i]  = m_pre[i];
        m_wait[i] = m_psc[i];
      end else if (tick[i]) begin
        m_wait[i] = m_psc[i];
        if (m_cnt[i] > 0) begin
          if (m_cnt[i] == 1) set = 1;
          m_cnt[i] = m_cnt[i] - 1;
        end else if (m_mode[i] == 2'b01) m_cnt[i] = m_pre[i];
        else if (m_mode[i] == 2'b10) m_cnt[i] = MASK;
        else m_en[i] = 0;
      end else if (m_en[i]) m_wait[i] = m_wait[i] - 1;
      else m_wait[i] = m_psc[i];
      if (set) m_pend[i] = 1;
      else if (hit && r == 3 && d[0]) m_pend[i] = 0;
    end
    m_irq = 0;
    for (int i = 0; i < NCH; i++) m_irq = m_irq | (m_pend[i] & m_im[i]);
  endfunction

  initial begin
    bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;

    // one-shot on ch1, then auto-reload with PSC=3 on ch0, then decode
    tq.push_back('{1'b1, 4'h5, 32'd3,     32'd0, 1'b0});
    tq.push_back('{1'b1, 4'h4, 32'h9,     32'd0, 1'b0});
    tq.push_back('{1'b0, 4'h6, 32'd0,     32'd3, 1'b0});
    tq.push_back('{1'b0, 4'h6, 32'd0,     32'd2, 1'b0});
    tq.push_back('{1'b0, 4'h6, 32'd0,     32'd1, 1'b1});
    tq.push_back('{1'b0, 4'h6, 32'd0,     32'd0, 1'b1});
    tq.push_back('{1'b0, 4'h4, 32'd0,     32'h8, 1'b1});
    tq.push_back('{1'b0, 4'h7, 32'd0,     32'd1, 1'b1});
    tq.push_back('{1'b1, 4'h7, 32'd1,     32'd1, 1'b0});
    tq.push_back('{1'b0, 4'h7, 32'd0,     32'd0, 1'b0});
    tq.push_back('{1'b0, 4'h6, 32'd0,     32'd0, 1'b0});
    tq.push_back('{1'b1, 4'h1, 32'd2,     32'd0, 1'b0});
    tq.push_back('{1'b1, 4'h0, 32'h30B,   32'd0, 1'b0});
    for (int i = 0; i < 4; i++) tq.push_back('{1'b0, 4'h2, 32'd0, 32'd2, 1'b0});
    for (int i = 0; i < 3; i++) tq.push_back('{1'b0, 4'h2, 32'd0, 32'd1, 1'b0});
    tq.push_back('{1'b0, 4'h2, 32'd0,     32'd1, 1'b1});
    for (int i = 0; i < 4; i++) tq.push_back('{1'b0, 4'h2, 32'd0, 32'd0, 1'b1});
    tq.push_back('{1'b0, 4'h0, 32'd0,     32'h30B, 1'b1});
    tq.push_back('{1'b1, 4'h3, 32'd1,     32'd1, 1'b0});
    tq.push_back('{1'b0, 4'h3, 32'd0,     32'd0, 1'b0});
    tq.push_back('{1'b1, 4'hC, 32'hF,     32'd0, 1'b0});
    tq.push_back('{1'b1, 4'h2, 32'h55,    32'd1, 1'b0});
    tq.push_back('{1'b0, 4'h2, 32'd0,     32'd1, 1'b0});
    tq.push_back('{1'b1, 4'h9, 32'hABCD1234, 32'd0, 1'b0});
    tq.push_back('{1'b0, 4'h9, 32'd0,     32'h1234, 1'b1});

    #2 rst = 1'b0;
    #1;
    chk("reset_do", bus.data_out, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tq.size(); i++) begin
      drive(tq[i].we, tq[i].a, tq[i].d);
      chk($sformatf("vec%0d_do", i), bus.data_out, tq[i].exp_do);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tq[i].exp_irq));
    end

    // asynchronous reset while counting
    bus.we = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_do", bus.data_out, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 4'h2, 0); chk("post_rst_count0", bus.data_out, 0);
    drive(1'b0, 4'h0, 0); chk("post_rst_ctrl0", bus.data_out, 0);
    drive(1'b0, 4'h9, 0); chk("post_rst_pre2", bus.data_out, 0);
    chk("post_rst_irq", 32'(irq), 32'd0);

    // collisions on ch0
    drive(1'b1, 4'h1, 5);
    drive(1'b1, 4'h0, 1);
    drive(1'b0, 4'h2, 0); chk("coll_cnt5", bus.data_out, 5);
    drive(1'b1, 4'h1, 7); chk("coll_pre_old", bus.data_out, 5);
    drive(1'b0, 4'h2, 0); chk("coll_pre_wins", bus.data_out, 7);
    drive(1'b0, 4'h2, 0); chk("coll_cnt6", bus.data_out, 6);
    drive(1'b1, 4'h1, 1);
    drive(1'b1, 4'h3, 1); chk("coll_pend_old", bus.data_out, 0);
    drive(1'b0, 4'h3, 0); chk("coll_set_wins", bus.data_out, 1);
    drive(1'b1, 4'h3, 1); chk("w1c_old", bus.data_out, 1);
    drive(1'b0, 4'h3, 0); chk("w1c_clear", bus.data_out, 0);
    drive(1'b0, 4'h0, 0); chk("oneshot_en_off", bus.data_out, 0);
    chk("coll_irq", 32'(irq), 32'd0);

    // free-run wrap on ch2
    drive(1'b1, 4'h9, 1);
    drive(1'b1, 4'h8, 5);
    drive(1'b0, 4'hA, 0); chk("fr_1", bus.data_out, 1);
    drive(1'b0, 4'hA, 0); chk("fr_0", bus.data_out, 0);
    drive(1'b0, 4'hA, 0); chk("fr_ffff", bus.data_out, 32'hFFFF);
    drive(1'b0, 4'hA, 0); chk("fr_fffe", bus.data_out, 32'hFFFE);
    chk("fr_irq_masked", 32'(irq), 32'd0);
    drive(1'b0, 4'hB, 0); chk("fr_pend", bus.data_out, 1);
    drive(1'b1, 4'h8, 32'hD); chk("fr_ctrl_old", bus.data_out, 5);
    chk("fr_irq_unmasked", 32'(irq), 32'd1);

    // random traffic against the model
    bus.we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_reset();
    for (int k = 0; k < 3000; k++) begin
      bit        we;
      bit [3:0]  a;
      bit [31:0] d;
      we = ($urandom_range(0, 99) < 30);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (a[1:0] == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
      if (a[1:0] == 2'd1 && $urandom_range(0, 3) != 0)
        d = $urandom_range(0, 6);
      drive(we, a, d);
      m_step(we, a, d);
      chk("rand_do", bus.data_out, m_dout);
      chk("rand_irq", 32'(irq), 32'(m_irq));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
